// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, receiver state encoding and the baud
// divisor helper used by both the receive and transmit paths.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int tick_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_rx_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is presented on o_data
// whenever the FIFO is non-empty.  A push while full is accepted only with a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_level == {(AW + 1){1'b0}});
    assign o_full    = (r_level == FULL_LVL);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Storage array, written on every accepted push.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {(AW + 1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (AW + 1)'(1);
                2'b01:   r_level <= r_level - (AW + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo_rx.sv
// 8N1 UART receiver with oversampled majority-vote bit recovery, feeding a
// byte FIFO presented as a valid/ready stream; framing errors and overruns pulse.
module uart_rx_fifo_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                        clk_100MHz,
    input  logic                        reset,
    input  logic                        uart_rx,
    output logic [UART_DATA_BITS-1:0]   m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        rx_busy,
    output logic                        frame_err,
    output logic                        overrun
);
    localparam int TICK_DIV = tick_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int OW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [OW-1:0] OS_SMP0   = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] OS_SMP1   = OW'(OVERSAMPLE / 2);
    localparam logic [OW-1:0] OS_VOTE   = OW'(OVERSAMPLE / 2 + 1);
    localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    logic                      r_sync1, r_sync2;
    rx_state_e                 r_state, w_next;
    logic [TW-1:0]             r_tick_cnt;
    logic [OW-1:0]             r_os_cnt;
    logic [2:0]                r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_smp0, r_smp1;
    logic                      w_tick, w_vote, w_vote_evt, w_bit_end;
    logic                      w_push, w_ferr, w_shift;
    logic                      r_push, r_busy, r_frame_err, r_overrun;
    logic                      w_full, w_empty, w_overflow;

    assign w_tick     = (r_state != IDLE) && (r_tick_cnt == TICK_LAST);
    assign w_vote_evt = w_tick && (r_os_cnt == OS_VOTE);
    assign w_bit_end  = w_tick && (r_os_cnt == OS_LAST);
    assign w_vote     = majority3(r_smp0, r_smp1, r_sync2);

    // Two-flop synchroniser on the asynchronous serial line.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; STOP leaves at mid-bit so the next start edge is not missed.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = r_sync2 ? IDLE : START;
            START: begin
                if (w_vote_evt && w_vote) begin
                    w_next = IDLE;
                end else if (w_bit_end) begin
                    w_next = DATA;
                end else begin
                    w_next = START;
                end
            end
            DATA:    w_next = (w_bit_end && (r_bit_cnt == BIT_LAST)) ? STOP : DATA;
            STOP: begin
                if (w_vote_evt) begin
                    w_next = w_vote ? IDLE : BREAK;
                end else begin
                    w_next = STOP;
                end
            end
            BREAK:   w_next = r_sync2 ? IDLE : BREAK;
            default: w_next = IDLE;
        endcase
    end

    // Per-state actions taken at the mid-bit vote.
    always_comb begin
        w_push  = 1'b0;
        w_ferr  = 1'b0;
        w_shift = 1'b0;
        if (r_state == STOP) begin
            w_push = w_vote_evt & w_vote;
            w_ferr = w_vote_evt & ~w_vote;
        end else if (r_state == DATA) begin
            w_shift = w_vote_evt;
        end else begin
            w_push = 1'b0;
        end
    end

    // Tick/oversample/bit counters and sample capture; counters sit at zero in IDLE.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_tick_cnt <= {TW{1'b0}};
            r_os_cnt   <= {OW{1'b0}};
            r_bit_cnt  <= 3'd0;
            r_shift    <= {UART_DATA_BITS{1'b0}};
            r_smp0     <= 1'b1;
            r_smp1     <= 1'b1;
        end else begin
            if ((r_state == IDLE) || w_tick) begin
                r_tick_cnt <= {TW{1'b0}};
            end else begin
                r_tick_cnt <= r_tick_cnt + TW'(1);
            end
            if (r_state == IDLE) begin
                r_os_cnt  <= {OW{1'b0}};
                r_bit_cnt <= 3'd0;
            end else if (w_tick) begin
                r_os_cnt <= (r_os_cnt == OS_LAST) ? {OW{1'b0}} : r_os_cnt + OW'(1);
                if ((r_state == DATA) && (r_os_cnt == OS_LAST)) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end
            if (w_tick && (r_os_cnt == OS_SMP0)) begin
                r_smp0 <= r_sync2;
            end
            if (w_tick && (r_os_cnt == OS_SMP1)) begin
                r_smp1 <= r_sync2;
            end
            if (w_shift) begin
                r_shift <= {w_vote, r_shift[UART_DATA_BITS-1:1]};
            end
        end
    end

    assign w_overflow = r_push & w_full & ~(m_ready & m_valid);

    // Registered status outputs and the push strobe into the FIFO.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_push      <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_push      <= w_push;
            r_busy      <= (w_next != IDLE);
            r_frame_err <= w_ferr;
            r_overrun   <= w_overflow;
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (clk_100MHz),
        .i_reset     (reset),
        .i_push      (r_push),
        .i_push_data (r_shift),
        .i_pop       (m_ready),
        .o_data      (m_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fifo_level)
    );

    assign m_valid   = ~w_empty;
    assign rx_busy   = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo_rx.sv
// Bench for uart_rx_fifo_rx: frame-level behavioural model (byte queue plus
// per-frame scheduled push / framing-error events) compared every cycle.
module tb_uart_rx_fifo_rx;
    localparam int CLK_HZ = 100000000;
    localparam int BAUD   = 1000000;
    localparam int OS     = 16;
    localparam int DEPTH  = 16;
    localparam int TD     = (CLK_HZ + BAUD * OS / 2) / (BAUD * OS);
    localparam int BIT    = TD * OS;
    // Third stop-bit sample is tick OS*9 + OS/2 + 2 after start detection; the
    // start edge costs 2 sync flops plus 1 cycle to leave IDLE, flags register 1 later.
    localparam int VOTE_TICK = OS * 9 + OS / 2 + 2;
    localparam int FERR_OFS  = 3 + TD * VOTE_TICK;
    localparam int PUSH_OFS  = FERR_OFS + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic [4:0] fifo_level;
    logic       rx_busy, frame_err, overrun;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    bit  rst_seen = 1'b1;
    bit  will_pop = 1'b0;
    bit  rand_rdy = 1'b0;
    logic [7:0] q[$];
    logic [7:0] drained[$];
    logic [7:0] push_val[int];
    bit         ferr_at[int];
    int  ferr_cnt = 0, ovr_cnt = 0, valid_cnt = 0, first_valid = -1;
    logic [7:0] last_data = 8'h00;

    uart_rx_fifo_rx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD),
        .OVERSAMPLE  (OS),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_level (fifo_level),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        rst_seen = reset;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model update for the edge just passed, then per-cycle comparison.
    initial forever begin
        @(negedge clk);
        if (rst_seen) begin
            q.delete();
            push_val.delete();
            ferr_at.delete();
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_fifo_level", fifo_level, 0);
            chk("rst_rx_busy", rx_busy, 0);
            chk("rst_frame_err", frame_err, 0);
            chk("rst_overrun", overrun, 0);
        end else begin
            bit ovr_exp;
            bit ferr_exp;
            ovr_exp  = 1'b0;
            ferr_exp = ferr_at.exists(cyc);
            if (push_val.exists(cyc)) begin
                ovr_exp = (q.size() == DEPTH) && !will_pop;
                if (will_pop) void'(q.pop_front());
                if (!ovr_exp) q.push_back(push_val[cyc]);
                push_val.delete(cyc);
            end else if (will_pop) begin
                void'(q.pop_front());
            end
            if (ferr_exp) ferr_at.delete(cyc);
            chk("m_valid", m_valid, q.size() != 0);
            chk("fifo_level", fifo_level, q.size());
            if (q.size() != 0) chk("m_data", m_data, q[0]);
            chk("frame_err", frame_err, ferr_exp);
            chk("overrun", overrun, ovr_exp);
        end
        will_pop = (q.size() != 0) && m_ready;
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (m_valid) begin
            valid_cnt++;
            last_data = m_data;
            if (first_valid < 0) first_valid = cyc;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ferr_cnt = 0; ovr_cnt = 0; valid_cnt = 0; first_valid = -1;
    endtask

    // Drives one frame (or its first nbits bits) and records the expected outcome.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bp, input int nbits);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        if (nbits == 10) begin
            if (stop_bit) push_val[cyc + PUSH_OFS] = b;
            else ferr_at[cyc + FERR_OFS] = 1'b1;
        end
        for (int i = 0; i < nbits; i++) begin
            uart_rx = bits[i];
            idle(bp);
        end
        uart_rx = 1'b1;
    endtask

    task automatic drain();
        drained.delete();
        m_ready = 1'b1;
        for (int k = 0; k < DEPTH + 4; k++) begin
            @(negedge clk);
            if (m_valid) drained.push_back(m_data);
            idle(1);
        end
        m_ready = 1'b0;
    endtask

    initial begin
        int s;
        int tgt;
        idle(5);
        reset = 1'b0;
        idle(5);

        // Single byte, consumer always ready.
        clr(); m_ready = 1'b1; s = cyc;
        send_frame(8'hA5, 1'b1, BIT, 10);
        idle(BIT);
        chk("t1_valid_cycles", valid_cnt, 1);
        chk("t1_data", last_data, 8'hA5);
        chk("t1_latency_window", (first_valid - s >= 9 * BIT) && (first_valid - s <= 10 * BIT), 1);
        chk("t1_no_flags", ferr_cnt + ovr_cnt, 0);

        // Short glitch on the idle line is rejected.
        clr(); uart_rx = 1'b0;
        idle(10);
        chk("t2_busy_during_glitch", rx_busy, 1);
        idle(10); uart_rx = 1'b1;
        idle(BIT - 20);
        chk("t2_busy_dropped", rx_busy, 0);
        chk("t2_no_output", valid_cnt + ferr_cnt, 0);
        send_frame(8'h5A, 1'b1, BIT, 10);
        idle(BIT);
        chk("t2_next_byte", last_data, 8'h5A);
        chk("t2_next_count", valid_cnt, 1);

        // Bad stop bit followed by a held-low break.
        clr();
        send_frame(8'h3C, 1'b0, BIT, 10);
        uart_rx = 1'b0;
        idle(3 * BIT);
        uart_rx = 1'b1;
        idle(2 * BIT);
        chk("t3_ferr_pulses", ferr_cnt, 1);
        chk("t3_fifo_empty", fifo_level, 0);
        chk("t3_idle_after_break", rx_busy, 0);
        send_frame(8'h55, 1'b1, BIT, 10);
        idle(BIT);
        chk("t3_next_byte", last_data, 8'h55);
        chk("t3_next_count", valid_cnt, 1);
        chk("t3_ferr_after", ferr_cnt, 1);

        // Overrun: 17 bytes into a 16-deep FIFO with no consumer.
        clr(); m_ready = 1'b0;
        for (int v = 0; v < 17; v++) send_frame(8'(v), 1'b1, BIT, 10);
        idle(BIT);
        chk("t4_level_full", fifo_level, 16);
        chk("t4_overrun_pulses", ovr_cnt, 1);
        drain();
        chk("t4_drained_count", drained.size(), 16);
        for (int i = 0; i < 16 && i < drained.size(); i++) chk("t4_drain_order", drained[i], 8'(i));

        // Full FIFO with a pop landing exactly on the push of the 17th byte.
        clr();
        for (int v = 0; v < 16; v++) send_frame(8'h20 + 8'(v), 1'b1, BIT, 10);
        tgt = cyc + PUSH_OFS;
        fork
            send_frame(8'h10, 1'b1, BIT, 10);
            begin
                while (cyc < tgt - 1) idle(1);
                m_ready = 1'b1;
                idle(1);
                m_ready = 1'b0;
            end
        join
        idle(BIT);
        chk("t5_no_overrun", ovr_cnt, 0);
        chk("t5_level_full", fifo_level, 16);
        drain();
        chk("t5_drained_count", drained.size(), 16);
        if (drained.size() == 16) begin
            chk("t5_head", drained[0], 8'h21);
            chk("t5_last", drained[15], 8'h10);
        end

        // Reset in the middle of data bit 3 with a byte already buffered.
        clr(); m_ready = 1'b0;
        send_frame(8'h11, 1'b1, BIT, 10);
        idle(BIT / 2);
        chk("t6_level_before", fifo_level, 1);
        send_frame(8'hF0, 1'b1, BIT, 4);
        uart_rx = 1'b0;
        idle(BIT / 2);
        reset = 1'b1; uart_rx = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("t6_level_after_rst", fifo_level, 0);
        chk("t6_valid_after_rst", m_valid, 0);
        chk("t6_busy_after_rst", rx_busy, 0);
        idle(BIT);
        clr(); m_ready = 1'b1;
        send_frame(8'h81, 1'b1, BIT, 10);
        idle(BIT);
        chk("t6_next_byte", last_data, 8'h81);
        chk("t6_next_count", valid_cnt, 1);

        // Sender 2% fast then 2% slow, back-to-back 0xFF / 0x00.
        for (int r = 0; r < 2; r++) begin
            clr();
            send_frame(8'hFF, 1'b1, (r == 0) ? BIT - 2 : BIT + 2, 10);
            send_frame(8'h00, 1'b1, (r == 0) ? BIT - 2 : BIT + 2, 10);
            idle(BIT);
            chk("t7_bytes", valid_cnt, 2);
            chk("t7_last", last_data, 8'h00);
            chk("t7_no_ferr", ferr_cnt, 0);
        end

        // Random bytes, occasional bad stop bits, random consumer back-pressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 12; n++) begin
            logic [7:0] b;
            logic       bad;
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, !bad, BIT - 1 + $urandom_range(0, 2), 10);
            if (bad) idle(BIT + $urandom_range(0, BIT));
            else idle($urandom_range(0, BIT / 2));
        end
        idle(BIT);
        rand_rdy = 1'b0;
        idle(1);
        m_ready = 1'b1;
        idle(DEPTH + 4);
        chk("rand_drained", fifo_level, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
